// File: rtl/forward_arbiter_pkg.sv
// Shared types and constants for the forward arbiter: session state encoding,
// default stream widths and the round-robin pointer advance helper.
package forward_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } fwd_state_t;

    localparam int FWD_DATA_W = 64;
    localparam int FWD_KEEP_W = 8;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned ports);
        return (idx + 1 >= ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/forward_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after rr_ptr,
// scanning upward with wrap-around.
module rr_picker #(
    parameter int PORT_NUM = 4,
    parameter int SEL_W    = $clog2(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [SEL_W-1:0]    rr_ptr,
    output logic [SEL_W-1:0]    idx,
    output logic                valid
);

    int k;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % PORT_NUM;
            if (req[k[SEL_W-1:0]]) begin
                idx   = k[SEL_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/forward_arbiter.sv
// Round-robin session arbiter: grants one forwarder at a time and muxes its stream
// onto a registered output. Optional idle timeout enabled by FWD_ARB_TIMEOUT_EN.
module forward_arbiter
    import forward_arbiter_pkg::*;
#(
    parameter int PORT_NUM    = 4,
    parameter int DATA_W      = FWD_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [PORT_NUM-1:0]          i_forward_req,
    output logic [PORT_NUM-1:0]          o_forward_resp,
    input  logic [PORT_NUM-1:0]          i_forward_finish,
    input  logic [PORT_NUM-1:0]          s_axis_tvalid,
    input  logic [PORT_NUM*DATA_W-1:0]   s_axis_tdata,
    input  logic [PORT_NUM-1:0]          s_axis_tlast,
    input  logic [PORT_NUM*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [PORT_NUM-1:0]          s_axis_tuser,
    output logic [PORT_NUM-1:0]          s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic [DATA_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tuser,
    input  logic                         m_axis_tready,
    output logic                         o_busy
`ifdef FWD_ARB_TIMEOUT_EN
    ,
    output logic                         o_timeout
`endif
);

    localparam int SEL_W  = $clog2(PORT_NUM);
    localparam int KEEP_W = DATA_W / 8;

    fwd_state_t        state;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              out_slot;
    logic              accept;
    logic              timeout_hit;

    rr_picker #(
        .PORT_NUM (PORT_NUM),
        .SEL_W    (SEL_W)
    ) u_picker (
        .req    (i_forward_req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign out_slot = !m_axis_tvalid || m_axis_tready;
    assign accept   = (state == XFER) && s_axis_tvalid[sel] && out_slot;
    assign o_busy   = (state != IDLE);

    // NOTE: default every output first so no path through the block leaves one unassigned (latch).
    always_comb begin
        s_axis_tready = '0;
        if (state == XFER) begin
            s_axis_tready[sel] = out_slot;
        end
    end

    // NOTE: registers take <= so each one samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            sel            <= '0;
            rr_ptr         <= '0;
            o_forward_resp <= '0;
        end else begin
            o_forward_resp <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel            <= pick_idx;
                        rr_ptr         <= SEL_W'(rr_next(int'(pick_idx), PORT_NUM));
                        o_forward_resp <= PORT_NUM'(1) << pick_idx;
                        state          <= XFER;
                    end
                end
                XFER: begin
                    if (accept && s_axis_tlast[sel] && i_forward_finish[sel]) begin
                        state <= DRAIN;
                    end else if (timeout_hit) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_slot) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the output payload is reset too, because it is visible on the port after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata[int'(sel)*DATA_W +: DATA_W];
            m_axis_tlast  <= s_axis_tlast[sel];
            m_axis_tkeep  <= s_axis_tkeep[int'(sel)*KEEP_W +: KEEP_W];
            m_axis_tuser  <= s_axis_tuser[sel];
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef FWD_ARB_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        mid_pkt;

    // The cycle that would bring the count to TIMEOUT_CYC is the one that ends the session.
    assign timeout_hit = (state == XFER) && !accept && !mid_pkt &&
                         (idle_cnt >= 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_cnt  <= '0;
            mid_pkt   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            if (state == IDLE && pick_valid) begin
                idle_cnt <= '0;
                mid_pkt  <= 1'b0;
            end else if (accept) begin
                idle_cnt <= '0;
                mid_pkt  <= !s_axis_tlast[sel];
            end else if (state == XFER && idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (timeout_hit) begin
                o_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_forward_arbiter.sv
// Randomised bench for forward_arbiter: per-port packet sources, a session-level
// reference model and an output scoreboard, all evaluated once per cycle.
module tb_forward_arbiter;

    localparam int P  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic            clk;
    logic            i_rst;
    logic [P-1:0]    i_forward_req;
    logic [P-1:0]    o_forward_resp;
    logic [P-1:0]    i_forward_finish;
    logic [P-1:0]    s_axis_tvalid;
    logic [P*DW-1:0] s_axis_tdata;
    logic [P-1:0]    s_axis_tlast;
    logic [P*KW-1:0] s_axis_tkeep;
    logic [P-1:0]    s_axis_tuser;
    logic [P-1:0]    s_axis_tready;
    logic            m_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tlast;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tuser;
    logic            m_axis_tready;
    logic            o_busy;
`ifdef FWD_ARB_TIMEOUT_EN
    logic            o_timeout;
`endif

    forward_arbiter #(
        .PORT_NUM    (P),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_forward_req    (i_forward_req),
        .o_forward_resp   (o_forward_resp),
        .i_forward_finish (i_forward_finish),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tready    (m_axis_tready),
        .o_busy           (o_busy)
`ifdef FWD_ARB_TIMEOUT_EN
        ,
        .o_timeout        (o_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sources and scoreboard
    beat_t        src_q[P][$];
    beat_t        exp_q[$];
    logic [P-1:0] req_hold;
    logic [P-1:0] granted;
    logic [P-1:0] vhold;

    // Session-level model of the arbiter
    bit           sess_open;
    bit           in_xfer;
    int           msel;
    int           mptr;
    logic [P-1:0] exp_resp;
    int           idle_m;
    bit           mid_m;
    bit           exp_to;

    bit           rst_req;
    int           rdy_mode;
    bit           rdy_t;
    int           valid_pct;
    int           beats_out;
    int           checks;
    int           failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_packet(input int p, input int len, input logic [KW-1:0] last_keep);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = (i == len - 1) ? last_keep : {KW{1'b1}};
            b.last = (i == len - 1);
            b.user = 1'($urandom_range(0, 1));
            src_q[p].push_back(b);
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = !sess_open && (exp_q.size() == 0) && (req_hold == '0);
        for (int p = 0; p < P; p++) begin
            if (src_q[p].size() != 0) q = 1'b0;
        end
        return q;
    endfunction

    task automatic drive();
        beat_t b;
        bit    v;
        i_rst = rst_req;
        for (int p = 0; p < P; p++) begin
            i_forward_req[p] = req_hold[p];
            if (granted[p] && src_q[p].size() > 0) begin
                b = src_q[p][0];
                v = vhold[p] || ($urandom_range(0, 99) < valid_pct);
                vhold[p]                = v;
                s_axis_tvalid[p]        = v;
                s_axis_tdata[p*DW +: DW] = b.data;
                s_axis_tkeep[p*KW +: KW] = b.keep;
                s_axis_tlast[p]         = b.last;
                s_axis_tuser[p]         = b.user;
                i_forward_finish[p]     = (src_q[p].size() == 1);
            end else begin
                // Waiting requesters wave garbage at the arbiter; none of it may get through.
                s_axis_tvalid[p]        = (req_hold[p] && !granted[p]) ? 1'($urandom_range(0, 1)) : 1'b0;
                s_axis_tdata[p*DW +: DW] = {$urandom, $urandom};
                s_axis_tkeep[p*KW +: KW] = KW'($urandom);
                s_axis_tlast[p]         = 1'($urandom_range(0, 1));
                s_axis_tuser[p]         = 1'($urandom_range(0, 1));
                i_forward_finish[p]     = (src_q[p].size() == 0);
            end
        end
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: begin
                rdy_t         = !rdy_t;
                m_axis_tready = rdy_t;
            end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One cycle: drive at the falling edge, compare, then advance the model to the next rising edge.
    task automatic step();
        logic [P-1:0] exp_tready;
        logic [P-1:0] next_resp;
        bit           was_open;
        bit           was_xfer;
        bit           slot;
        bit           acc;
        bit           found;
        int           k;
        beat_t        b;

        @(negedge clk);
        drive();
        #1;
        slot       = (exp_q.size() == 0) || m_axis_tready;
        exp_tready = '0;
        if (in_xfer && slot) exp_tready[msel] = 1'b1;

        check("forward_resp", o_forward_resp, exp_resp);
        check("busy", o_busy, sess_open);
        check("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
        check("s_tready", s_axis_tready, exp_tready);
`ifdef FWD_ARB_TIMEOUT_EN
        check("timeout_flag", o_timeout, exp_to);
`endif

        if (rst_req) begin
            exp_q.delete();
            for (int p = 0; p < P; p++) src_q[p].delete();
            sess_open = 0;
            in_xfer   = 0;
            msel      = 0;
            mptr      = 0;
            exp_resp  = '0;
            exp_to    = 0;
            granted   = '0;
            vhold     = '0;
            req_hold  = '0;
            return;
        end

        was_open  = sess_open;
        was_xfer  = in_xfer;
        next_resp = '0;
        acc       = in_xfer && s_axis_tvalid[msel] && exp_tready[msel];

        if (exp_q.size() != 0 && m_axis_tready) begin
            b = exp_q.pop_front();
            beats_out++;
            check("m_tdata", m_axis_tdata, b.data);
            check("m_tkeep", m_axis_tkeep, b.keep);
            check("m_tlast", m_axis_tlast, b.last);
            check("m_tuser", m_axis_tuser, b.user);
        end

        if (acc) begin
            b = src_q[msel].pop_front();
            exp_q.push_back(b);
            vhold[msel] = 1'b0;
            idle_m      = 0;
            mid_m       = !b.last;
            if (b.last && i_forward_finish[msel]) begin
                in_xfer       = 0;
                granted[msel] = 1'b0;
            end
        end else if (was_xfer) begin
`ifdef FWD_ARB_TIMEOUT_EN
            idle_m++;
            if (idle_m >= TO && !mid_m) begin
                in_xfer       = 0;
                granted[msel] = 1'b0;
                exp_to        = 1;
            end
`endif
        end

        if (was_open && !was_xfer && slot) sess_open = 0;

        if (!was_open && i_forward_req != '0) begin
            found = 0;
            for (int i = 0; i < P; i++) begin
                k = (mptr + i) % P;
                if (!found && i_forward_req[k]) begin
                    found = 1;
                    msel  = k;
                end
            end
            mptr            = (msel + 1) % P;
            next_resp[msel] = 1'b1;
            sess_open       = 1;
            in_xfer         = 1;
            granted[msel]   = 1'b1;
            req_hold[msel]  = 1'b0;
            idle_m          = 0;
            mid_m           = 0;
        end
        exp_resp = next_resp;
    endtask

    task automatic run_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            step();
            n++;
        end
        check(tag, quiet(), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdata"}, m_axis_tdata, '0);
        check({tag, "_tkeep"}, m_axis_tkeep, '0);
        check({tag, "_tlast"}, m_axis_tlast, 1'b0);
        check({tag, "_tuser"}, m_axis_tuser, 1'b0);
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
        step();
        rst_req = 0;
        step();
    endtask

    initial begin
        int n0;
        checks    = 0;
        failures  = 0;
        beats_out = 0;
        req_hold  = '0;
        granted   = '0;
        vhold     = '0;
        sess_open = 0;
        in_xfer   = 0;
        msel      = 0;
        mptr      = 0;
        exp_resp  = '0;
        idle_m    = 0;
        mid_m     = 0;
        exp_to    = 0;
        rdy_mode  = 0;
        rdy_t     = 0;
        valid_pct = 100;
        rst_req   = 1;
        i_rst            = 1'b1;
        i_forward_req    = '0;
        i_forward_finish = '0;
        s_axis_tvalid    = '0;
        s_axis_tdata     = '0;
        s_axis_tlast     = '0;
        s_axis_tkeep     = '0;
        s_axis_tuser     = '0;
        m_axis_tready    = 1'b1;

        // Reset state
        repeat (2) step();
        rst_req = 0;
        step();
        check_reset_outputs("rst");

        // Single 3-beat packet on port 2 with a partial last keep
        add_packet(2, 3, 8'h0f);
        req_hold[2] = 1'b1;
        run_quiet("single_done", 100);

        // Simultaneous requests from ports 0 and 3 after reset: 0 first, then 3
        do_reset();
        add_packet(0, 3, 8'hff);
        add_packet(3, 2, 8'h01);
        req_hold[0] = 1'b1;
        req_hold[3] = 1'b1;
        run_quiet("pair_done", 200);

        // Two packets in one session on port 1; port 0 requests mid-session
        add_packet(1, 4, 8'hff);
        add_packet(1, 4, 8'h07);
        req_hold[1] = 1'b1;
        repeat (4) step();
        add_packet(0, 2, 8'h03);
        req_hold[0] = 1'b1;
        run_quiet("multi_done", 200);

        // Output backpressure toggling during a 5-beat packet
        rdy_mode = 1;
        add_packet(3, 5, 8'h3f);
        req_hold[3] = 1'b1;
        run_quiet("toggle_done", 200);
        rdy_mode = 0;

        // Reset in the middle of a 4-beat packet, then a fresh session
        add_packet(1, 4, 8'hff);
        req_hold[1] = 1'b1;
        n0 = beats_out;
        for (int i = 0; i < 50 && beats_out < n0 + 2; i++) step();
        check("midrst_setup", beats_out - n0, 2);
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check_reset_outputs("midrst");
        add_packet(2, 3, 8'h1f);
        req_hold[2] = 1'b1;
        run_quiet("after_rst_done", 100);

        // Randomised sessions with random backpressure and source gaps
        rdy_mode  = 2;
        valid_pct = 70;
        for (int r = 0; r < 12; r++) begin
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 99) < 60) begin
                    int npk;
                    npk = $urandom_range(1, 2);
                    for (int j = 0; j < npk; j++) begin
                        add_packet(p, $urandom_range(1, 6), KW'($urandom_range(1, 255)));
                    end
                    req_hold[p] = 1'b1;
                end
            end
            run_quiet("random_done", 2000);
        end
        rdy_mode  = 0;
        valid_pct = 100;

`ifdef FWD_ARB_TIMEOUT_EN
        // Port 0 granted but silent; port 1 waits behind it
        do_reset();
        req_hold[0] = 1'b1;
        add_packet(1, 2, 8'hff);
        req_hold[1] = 1'b1;
        run_quiet("timeout_done", 200);
        check("timeout_sticky", o_timeout, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
